// File: rtl/fastica_pkg.sv
// rtl/fastica_pkg.sv - shared fixed-point widths, operand type and cuber latency for the FastICA update stage
package fastica_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_WIDTH = 10;
  localparam int CUBE_LAT   = 3;

  // Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH signed operand/result
  typedef logic signed [DATA_WIDTH-1:0] fx_t;

endpackage

// File: rtl/fastica_cube3.sv
// rtl/fastica_cube3.sv - 3-stage pipelined signed fixed-point cuber, no stall
module fastica_cube3 #(
  parameter int DATA_WIDTH = fastica_pkg::DATA_WIDTH,
  parameter int FRAC_WIDTH = fastica_pkg::FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                           r_v1, r_v2, r_v3;
  logic signed [DATA_WIDTH-1:0]   r_x1, r_x2;
  logic signed [2*DATA_WIDTH-1:0] r_sq;
  logic signed [DATA_WIDTH-1:0]   r_y;
  logic signed [3*DATA_WIDTH-1:0] w_prod;

  assign w_prod = (3*DATA_WIDTH)'(r_sq) * (3*DATA_WIDTH)'(r_x2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_sq <= '0;
      r_y  <= '0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (i_valid) r_x1 <= i_data;
      if (r_v1) begin
        r_sq <= (2*DATA_WIDTH)'(r_x1) * (2*DATA_WIDTH)'(r_x1);
        r_x2 <= r_x1;
      end
      // Arithmetic shift floors toward -inf; upper bits wrap on overflow
      if (r_v2) r_y <= DATA_WIDTH'(w_prod >>> (2*FRAC_WIDTH));
    end
  end

  assign o_valid = r_v3;
  assign o_data  = r_y;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with gated grant and rotating priority pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_win;
  logic             w_found;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_en && w_found) o_grant[w_win] = 1'b1;
  end

  assign o_idx = w_win;

  // Pointer only moves on an actual grant, so en=0 freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_win == IDX_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/cube_share_arbiter.sv
// rtl/cube_share_arbiter.sv - round-robin sharing of one cuber among NUM_REQ requesters, tagged result routing
module cube_share_arbiter #(
  parameter int DATA_WIDTH = fastica_pkg::DATA_WIDTH,
  parameter int FRAC_WIDTH = fastica_pkg::FRAC_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [IDX_W-1:0]              rsp_tag,
  output logic [1:0]                    inflight,
  output logic                          busy
);
  import fastica_pkg::*;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_operand;
  logic                  w_cube_vld;
  logic [DATA_WIDTH-1:0] w_cube_data;

  logic [IDX_W-1:0]      r_tag [CUBE_LAT];
  logic [CUBE_LAT-2:0]   r_tv;
  logic [1:0]            r_inflight;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_req   (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready = w_grant;
  assign w_issue   = |w_grant;
  assign w_operand = req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];

  fastica_cube3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_cube (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_issue),
    .i_data  (w_operand),
    .o_valid (w_cube_vld),
    .o_data  (w_cube_data)
  );

  // Tag stages load only behind a valid, so the last one holds the owner of rsp_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv <= '0;
      for (int s = 0; s < CUBE_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tv[0] <= w_issue;
      if (w_issue) r_tag[0] <= w_idx;
      for (int s = 1; s < CUBE_LAT-1; s++) r_tv[s] <= r_tv[s-1];
      for (int s = 1; s < CUBE_LAT; s++) begin
        if (r_tv[s-1]) r_tag[s] <= r_tag[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_cube_vld})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign rsp_tag   = r_tag[CUBE_LAT-1];
  assign rsp_data  = w_cube_data;
  assign rsp_valid = w_cube_vld ? (NUM_REQ'(1) << rsp_tag) : '0;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != 2'd0) || (|req_valid);

endmodule

// File: doc/cube_share_arbiter.md
Name: cube_share_arbiter

Overview:
- Shares one pipelined fixed-point cubing datapath among NUM_REQ requesters in the FastICA weight-update stage (the per-lane g(u)=u^3 nonlinearity).
- Arbitrates round-robin, issues at most one operand per cycle into the 3-stage cuber, and carries a requester tag alongside the pipeline.
- Routes each result back to the requester that issued it.

Parameters:
- DATA_WIDTH, 16, operand/result width, signed fixed point.
- FRAC_WIDTH, 10, fractional bits of operand and result.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  grant enable; 0 blocks new grants while in-flight ops drain.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant (accept) this cycle.
- rsp_valid  out  NUM_REQ  one-hot result strobe.
- rsp_data  out  DATA_WIDTH  result shared by all requesters; qualified by rsp_valid.
- rsp_tag  out  IDX_W  index of the requester owning rsp_data.
- inflight  out  2  number of operations currently in the cuber (0..3).
- busy  out  1  inflight!=0 or any req_valid.

Behaviour:
- Reset is asynchronous and active-low; clock is clk. On reset: rsp_valid=0, rsp_data=0, rsp_tag=0, inflight=0, round-robin pointer=0, all tag and valid pipeline stages cleared. Any operation in flight is discarded and produces no response.
- req_ready is combinational from req_valid, en and the pointer. At most one bit is set, and only when en=1.
- Transfer on requester i: req_valid[i] & req_ready[i]. Requesters hold req_valid and req_data stable until accepted.
- Round-robin:
  - Search starts at pointer p. The first i in p, p+1, ..., p+NUM_REQ-1 (mod NUM_REQ) with req_valid[i] wins.
  - After a grant to i, p <= (i+1) mod NUM_REQ.
  - No grant leaves p unchanged.
  - Wrap from NUM_REQ-1 to 0 is required.
- Issue: a transfer drives the cuber start with the granted operand and pushes tag i into a 3-deep tag shift register that advances in lockstep with the cuber valids.
- Cuber pipeline, fixed latency of 3 cycles, no stall:
  - Stage 1 registers x.
  - Stage 2 registers x*x (2*DATA_WIDTH bits) and x.
  - Stage 3 computes the full 3*DATA_WIDTH signed product and outputs bits [2*FRAC_WIDTH +: DATA_WIDTH]. This is arithmetic truncation toward -inf; overflow wraps; no saturation.
- Latency: a transfer at edge N gives rsp_valid[i]=1 for exactly one cycle after edge N+3, with rsp_data and rsp_tag=i. Throughput is 1 result per cycle.
- There is no response backpressure; requesters must always sink rsp_valid.
- rsp_data and rsp_tag hold their last value when rsp_valid=0.
- inflight: +1 on a transfer and -1 on rsp_valid in the same update; a simultaneous issue and retire leaves it unchanged.
- en deasserted mid-stream: in-flight ops complete normally and the pointer is frozen.
- Single requester continuously valid: granted every cycle.
- All NUM_REQ requesters continuously valid: grants cycle 0, 1, ..., NUM_REQ-1, 0, ...

Decomposition:
- Shared package (fastica_pkg):
  - DATA_WIDTH/FRAC_WIDTH defaults.
  - Fixed-point type alias for the Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH operand.
  - Constant for cuber latency (CUBE_LAT=3), used by the tag pipeline and by the testbench.
- Sub-modules:
  - The existing 3-stage cuber datapath is instantiated unchanged.
  - One new sub-module, rr_arbiter (NUM_REQ, req vector, en, one-hot grant, pointer update), is natural and reusable elsewhere in the update block.

Test Plan:
- Reset, then requester 0 sends 1024 (1.0): req_ready[0]=1 in that cycle; 3 cycles later rsp_valid=0001, rsp_data=1024, rsp_tag=0, inflight returns to 0.
- Operands issued back-to-back from requester 1: 2048, -1536, 512 -> consecutive results 8192, -3456, 128, all with tag 1; inflight peaks at 3.
- All 4 requesters valid and held for 8 cycles, pointer starting at 0 -> grants 0,1,2,3,0,1,2,3; rsp_tag follows the same order with a 3-cycle delay.
- Requesters 3 and 0 valid with pointer=3 -> 3 granted, then 0 (wrap); pointer becomes 1.
- en dropped while 2 ops are in flight and requester 2 is valid -> no req_ready; both results emerge on schedule; requester 2 is granted the first cycle after en=1.
- rst_n asserted with 3 ops in flight -> outputs 0 immediately; no rsp_valid after release; first new op has normal 3-cycle latency.
